// File: rtl/bus_initiator_pkg.sv
// Shared encodings for the bus-side MESI transaction engine: line states,
// engine states, bus command kinds and the miss/upgrade classifier.
package bus_initiator_pkg;

  localparam int ADDRESSSIZE = 32;
  localparam int MESI_SIZE   = 2;

  typedef enum logic [1:0] {
    INVALID   = 2'b00,
    SHARED    = 2'b01,
    EXCLUSIVE = 2'b10,
    MODIFIED  = 2'b11
  } mesi_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    WB    = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4,
    DONE  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    CMD_HIT    = 2'd0,
    CMD_BUSRD  = 2'd1,
    CMD_BUSRDX = 2'd2,
    CMD_INV    = 2'd3
  } cmd_e;

  // Owned lines and shared reads complete locally; everything else needs the bus.
  function automatic cmd_e classify(input logic [MESI_SIZE-1:0] line_state,
                                    input logic                 is_write);
    cmd_e cmd;
    case (line_state)
      MODIFIED, EXCLUSIVE: cmd = CMD_HIT;
      SHARED:              cmd = is_write ? CMD_INV : CMD_HIT;
      INVALID:             cmd = is_write ? CMD_BUSRDX : CMD_BUSRD;
      default:             cmd = CMD_HIT;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/bus_initiator.sv
// Bus-side transaction engine: arbitrates for the snoop bus, writes back a
// Modified victim when needed, issues BusRd/BusRdX/Invalidate and collects the fill.
module bus_initiator
  import bus_initiator_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   PrRd,
  input  logic                   PrWr,
  input  logic [ADDRESSSIZE-1:0] Address,
  input  logic [MESI_SIZE-1:0]   Current_MESI_state_proc,
  input  logic [MESI_SIZE-1:0]   Victim_MESI_state,
  input  logic [ADDRESSSIZE-1:0] Victim_address,
  input  logic [ADDRESSSIZE-1:0] Victim_data,
  output logic                   Bus_req,
  input  logic                   Bus_grant,
  output logic                   BusRd,
  output logic                   BusRdX,
  output logic                   Invalidate,
  output logic                   Mem_wr,
  output logic [ADDRESSSIZE-1:0] Address_Com,
  output logic [ADDRESSSIZE-1:0] Data_Bus_Com_out,
  input  logic [ADDRESSSIZE-1:0] Data_Bus_Com_in,
  input  logic                   Shared,
  input  logic                   Snoop_done,
  input  logic                   Mem_ready,
  output logic [ADDRESSSIZE-1:0] Fill_data,
  output logic                   Fill_shared,
  output logic                   Pr_done,
  output logic                   Bus_error
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e                 state_r, state_next_s;
  cmd_e                   cmd_r, cmd_new_s;
  logic                   wb_r, wb_new_s;
  logic [ADDRESSSIZE-1:0] addr_r, vic_addr_r, vic_data_r;
  logic [CW-1:0]          cnt_r, cnt_next_s;
  logic                   req_s, expired_s, wait_ok_s, timeout_s;

  logic                   bus_req_s, busrd_s, busrdx_s, inv_s, mem_wr_s, pr_done_s, bus_error_s;
  logic [ADDRESSSIZE-1:0] addr_com_s, data_out_s, fill_data_s;
  logic                   fill_shared_s;
  logic                   bus_req_r, busrd_r, busrdx_r, inv_r, mem_wr_r, pr_done_r, bus_error_r;
  logic [ADDRESSSIZE-1:0] addr_com_r, data_out_r, fill_data_r;
  logic                   fill_shared_r;

  // State register and timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state decode; progress on the bus takes priority over an expiring timer.
  always_comb begin
    state_next_s = state_r;
    timeout_s    = 1'b0;
    req_s        = PrRd | PrWr;
    cmd_new_s    = classify(Current_MESI_state_proc, PrWr);
    wb_new_s     = ((cmd_new_s == CMD_BUSRD) || (cmd_new_s == CMD_BUSRDX)) &&
                   (Victim_MESI_state == MODIFIED);
    expired_s    = (cnt_r == CW'(TIMEOUT - 1));
    wait_ok_s    = Snoop_done && ((cmd_r == CMD_INV) || Mem_ready);
    case (state_r)
      IDLE: begin
        if (req_s) state_next_s = (cmd_new_s == CMD_HIT) ? DONE : ARB;
        else       state_next_s = IDLE;
      end
      ARB: begin
        if (Bus_grant)      state_next_s = wb_r ? WB : ISSUE;
        else if (expired_s) begin state_next_s = IDLE; timeout_s = 1'b1; end
        else                state_next_s = ARB;
      end
      WB: begin
        if (Mem_ready)      state_next_s = ISSUE;
        else if (expired_s) begin state_next_s = IDLE; timeout_s = 1'b1; end
        else                state_next_s = WB;
      end
      ISSUE: state_next_s = WAIT;
      WAIT: begin
        if (wait_ok_s)      state_next_s = DONE;
        else if (expired_s) begin state_next_s = IDLE; timeout_s = 1'b1; end
        else                state_next_s = WAIT;
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Timer restarts on every state change and only runs while waiting on others.
  always_comb begin
    if (state_next_s != state_r) begin
      cnt_next_s = {CW{1'b0}};
    end else if ((state_r == ARB) || (state_r == WB) || (state_r == WAIT)) begin
      cnt_next_s = cnt_r + CW'(1);
    end else begin
      cnt_next_s = {CW{1'b0}};
    end
  end

  // Request capture at acceptance; held until the engine returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_r      <= CMD_HIT;
      wb_r       <= 1'b0;
      addr_r     <= {ADDRESSSIZE{1'b0}};
      vic_addr_r <= {ADDRESSSIZE{1'b0}};
      vic_data_r <= {ADDRESSSIZE{1'b0}};
    end else if ((state_r == IDLE) && req_s) begin
      cmd_r      <= cmd_new_s;
      wb_r       <= wb_new_s;
      addr_r     <= Address;
      vic_addr_r <= Victim_address;
      vic_data_r <= Victim_data;
    end
  end

  // Bus-facing outputs decoded from the state being entered, so they register in step with it.
  always_comb begin
    bus_req_s   = 1'b0;
    busrd_s     = 1'b0;
    busrdx_s    = 1'b0;
    inv_s       = 1'b0;
    mem_wr_s    = 1'b0;
    addr_com_s  = {ADDRESSSIZE{1'b0}};
    data_out_s  = {ADDRESSSIZE{1'b0}};
    pr_done_s   = (state_next_s == DONE);
    bus_error_s = timeout_s;
    case (state_next_s)
      ARB, WAIT: bus_req_s = 1'b1;
      WB: begin
        bus_req_s = 1'b1;
        // Only the ARB->WB entry carries the write strobe; later WB cycles just wait.
        if (state_r == ARB) begin
          mem_wr_s   = 1'b1;
          addr_com_s = vic_addr_r;
          data_out_s = vic_data_r;
        end else begin
          mem_wr_s   = 1'b0;
        end
      end
      ISSUE: begin
        bus_req_s  = 1'b1;
        addr_com_s = addr_r;
        busrd_s    = (cmd_r == CMD_BUSRD);
        busrdx_s   = (cmd_r == CMD_BUSRDX);
        inv_s      = (cmd_r == CMD_INV);
      end
      default: bus_req_s = 1'b0;
    endcase
  end

  // Fill capture: Shared is OR-accumulated across WAIT, data taken on the completing cycle.
  always_comb begin
    fill_data_s   = fill_data_r;
    fill_shared_s = fill_shared_r;
    case (state_r)
      ISSUE: fill_shared_s = 1'b0;
      WAIT: begin
        fill_shared_s = fill_shared_r | Shared;
        if (wait_ok_s && (cmd_r != CMD_INV)) fill_data_s = Data_Bus_Com_in;
        else                                 fill_data_s = fill_data_r;
      end
      default: begin
        fill_data_s   = fill_data_r;
        fill_shared_s = fill_shared_r;
      end
    endcase
  end

  // Output registers; the asynchronous reset releases the bus immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req_r     <= 1'b0;
      busrd_r       <= 1'b0;
      busrdx_r      <= 1'b0;
      inv_r         <= 1'b0;
      mem_wr_r      <= 1'b0;
      addr_com_r    <= {ADDRESSSIZE{1'b0}};
      data_out_r    <= {ADDRESSSIZE{1'b0}};
      pr_done_r     <= 1'b0;
      bus_error_r   <= 1'b0;
      fill_data_r   <= {ADDRESSSIZE{1'b0}};
      fill_shared_r <= 1'b0;
    end else begin
      bus_req_r     <= bus_req_s;
      busrd_r       <= busrd_s;
      busrdx_r      <= busrdx_s;
      inv_r         <= inv_s;
      mem_wr_r      <= mem_wr_s;
      addr_com_r    <= addr_com_s;
      data_out_r    <= data_out_s;
      pr_done_r     <= pr_done_s;
      bus_error_r   <= bus_error_s;
      fill_data_r   <= fill_data_s;
      fill_shared_r <= fill_shared_s;
    end
  end

  assign Bus_req          = bus_req_r;
  assign BusRd            = busrd_r;
  assign BusRdX           = busrdx_r;
  assign Invalidate       = inv_r;
  assign Mem_wr           = mem_wr_r;
  assign Address_Com      = addr_com_r;
  assign Data_Bus_Com_out = data_out_r;
  assign Pr_done          = pr_done_r;
  assign Bus_error        = bus_error_r;
  assign Fill_data        = fill_data_r;
  assign Fill_shared      = fill_shared_r;

endmodule

// File: tb/tb_bus_initiator.sv
// Self-checking bench for bus_initiator: directed scenarios plus randomized
// transactions checked against a transaction-level timeline model.
module tb_bus_initiator;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PrRd, PrWr;
  logic [31:0] Address;
  logic [1:0]  Current_MESI_state_proc, Victim_MESI_state;
  logic [31:0] Victim_address, Victim_data;
  logic        Bus_req, Bus_grant;
  logic        BusRd, BusRdX, Invalidate, Mem_wr;
  logic [31:0] Address_Com, Data_Bus_Com_out, Data_Bus_Com_in;
  logic        Shared, Snoop_done, Mem_ready;
  logic [31:0] Fill_data;
  logic        Fill_shared, Pr_done, Bus_error;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_fill;
  logic        m_shared;

  bus_initiator #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .PrRd(PrRd), .PrWr(PrWr), .Address(Address),
    .Current_MESI_state_proc(Current_MESI_state_proc), .Victim_MESI_state(Victim_MESI_state),
    .Victim_address(Victim_address), .Victim_data(Victim_data),
    .Bus_req(Bus_req), .Bus_grant(Bus_grant), .BusRd(BusRd), .BusRdX(BusRdX),
    .Invalidate(Invalidate), .Mem_wr(Mem_wr), .Address_Com(Address_Com),
    .Data_Bus_Com_out(Data_Bus_Com_out), .Data_Bus_Com_in(Data_Bus_Com_in),
    .Shared(Shared), .Snoop_done(Snoop_done), .Mem_ready(Mem_ready),
    .Fill_data(Fill_data), .Fill_shared(Fill_shared), .Pr_done(Pr_done), .Bus_error(Bus_error)
  );

  always #5 clk = ~clk;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 32'({Bus_req, BusRd, BusRdX, Invalidate, Mem_wr, Pr_done, Bus_error, Fill_shared}), 32'd0);
    chk({tag, "_addr"}, Address_Com, 32'd0);
    chk({tag, "_wdata"}, Data_Bus_Com_out, 32'd0);
    chk({tag, "_fill"}, Fill_data, 32'd0);
  endtask

  // One processor request; responders react to observed bus strobes with the given delays.
  task automatic run_txn(input logic rd, input logic wr, input logic [1:0] st, input logic [1:0] vst,
                         input int g, input int w, input int s, input int m, input int sh_mode,
                         input logic [31:0] a, input logic [31:0] va, input logic [31:0] vd,
                         input logic [31:0] fd, input int rst_at);
    logic        hit, is_inv, is_rd, is_rdx, wb, exp_err, reached_issue, reached_wait, exp_wr;
    logic        got_done, got_err, acc_sh, sh, was_reset;
    logic [2:0]  cmd_seen;
    logic [31:0] cmd_addr, wr_addr, wr_data, exp_fill;
    int          jdone, t, exp_end, phase, arb_cnt, wb_cnt, wait_j, req_cycles, n_cmd, n_wr, n_strb, end_cyc;

    hit    = (st == 2'b11) || (st == 2'b10) || ((st == 2'b01) && !wr);
    is_inv = (st == 2'b01) && wr;
    is_rd  = (st == 2'b00) && !wr;
    is_rdx = (st == 2'b00) && wr;
    wb     = (is_rd || is_rdx) && (vst == 2'b11);
    jdone  = is_inv ? s + 1 : ((s > m) ? s : m) + 1;
    exp_fill = (is_rd || is_rdx) ? fd : m_fill;

    // Expected timeline: cycle 0 = request, each waiting phase may expire after TO cycles.
    exp_err = 1'b0; reached_issue = 1'b0; reached_wait = 1'b0; t = 1;
    if (hit) exp_end = 1;
    else if (g + 1 > TO) begin exp_err = 1'b1; exp_end = t + TO; end
    else begin
      t += g + 1;
      if (wb && (w + 1 > TO)) begin exp_err = 1'b1; exp_end = t + TO; end
      else begin
        if (wb) t += w + 1;
        reached_issue = 1'b1; reached_wait = 1'b1; t += 1;
        if (jdone > TO) begin exp_err = 1'b1; exp_end = t + TO; end
        else exp_end = t + jdone;
      end
    end
    exp_wr = wb && (g + 1 <= TO);

    got_done = 1'b0; got_err = 1'b0; acc_sh = 1'b0; was_reset = 1'b0; cmd_seen = 3'b000;
    cmd_addr = 32'd0; wr_addr = 32'd0; wr_data = 32'd0;
    phase = 0; arb_cnt = 0; wb_cnt = 0; wait_j = 0; req_cycles = 0; n_cmd = 0; n_wr = 0; end_cyc = 0;

    @(negedge clk);
    PrRd = rd; PrWr = wr; Current_MESI_state_proc = st; Victim_MESI_state = vst;
    Address = a; Victim_address = va; Victim_data = vd;
    Bus_grant = rbit(); Shared = rbit(); Snoop_done = rbit(); Mem_ready = rbit(); Data_Bus_Com_in = $urandom;

    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      n_strb = int'(BusRd) + int'(BusRdX) + int'(Invalidate) + int'(Mem_wr);
      chk("strobe_onehot", 32'(n_strb <= 1), 32'd1);
      if (n_strb == 0) chk("addr_idle_zero", Address_Com, 32'd0);
      if (Bus_req) req_cycles++;
      if (Mem_wr) begin n_wr++; wr_addr = Address_Com; wr_data = Data_Bus_Com_out; end
      if (BusRd || BusRdX || Invalidate) begin
        n_cmd++; cmd_seen = {BusRd, BusRdX, Invalidate}; cmd_addr = Address_Com;
      end
      if (Pr_done) begin
        got_done = 1'b1; got_err = Bus_error; end_cyc = cyc;
        chk("fill_data", Fill_data, exp_fill);
        chk("fill_shared", 32'(Fill_shared), 32'(hit ? m_shared : acc_sh));
        chk("req_low_at_done", 32'(Bus_req), 32'd0);
        break;
      end
      if (Bus_error) begin
        got_err = 1'b1; end_cyc = cyc;
        chk("req_low_at_error", 32'(Bus_req), 32'd0);
        chk("fill_kept_on_error", Fill_data, m_fill);
        break;
      end
      // Request-side inputs other than PrRd/PrWr must be ignored after acceptance.
      Address = $urandom; Current_MESI_state_proc = 2'($urandom_range(0, 3));
      Victim_MESI_state = 2'($urandom_range(0, 3)); Victim_address = $urandom; Victim_data = $urandom;

      if (BusRd || BusRdX || Invalidate) begin phase = 2; wait_j = 0; end
      else if (phase == 2) wait_j++;
      if (Mem_wr) begin phase = 1; wb_cnt = 0; end
      if (phase == 1) wb_cnt++;

      Shared = rbit(); Snoop_done = rbit(); Mem_ready = rbit(); Data_Bus_Com_in = $urandom;
      if (phase == 0) begin
        if (Bus_req) begin arb_cnt++; Bus_grant = (arb_cnt > g); end
        else Bus_grant = rbit();
      end else if (phase == 1) begin
        Bus_grant = rbit(); Mem_ready = (wb_cnt > w);
      end else begin
        Bus_grant = rbit();
        if (wait_j >= 1) begin
          Snoop_done = (wait_j > s); Mem_ready = (wait_j > m);
          sh = (sh_mode == 1) ? 1'b1 : rbit();
          Shared = sh;
          if (wait_j <= jdone) acc_sh = acc_sh | sh;
          if (wait_j == jdone) Data_Bus_Com_in = fd;
        end
      end

      if ((rst_at > 0) && (phase == 2) && (wait_j == rst_at)) begin
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        PrRd = 1'b0; PrWr = 1'b0;
        #1 rst_n = 1'b1;
        was_reset = 1'b1;
        break;
      end
    end
    PrRd = 1'b0; PrWr = 1'b0; Bus_grant = 1'b0; Mem_ready = 1'b0; Snoop_done = 1'b0; Shared = 1'b0;

    if (was_reset) begin
      m_fill = 32'd0; m_shared = 1'b0;
    end else begin
      chk("end_kind", 32'({got_done, got_err}), exp_err ? 32'd1 : 32'd2);
      chk("end_cycle", 32'(end_cyc), 32'(exp_end));
      chk("req_cycles", 32'(req_cycles), hit ? 32'd0 : 32'(exp_end - 1));
      chk("cmd_count", 32'(n_cmd), 32'(reached_issue));
      if (reached_issue) begin
        chk("cmd_kind", 32'(cmd_seen), 32'({is_rd, is_rdx, is_inv}));
        chk("cmd_addr", cmd_addr, a);
      end
      chk("memwr_count", 32'(n_wr), 32'(exp_wr));
      if (exp_wr) begin
        chk("wb_addr", wr_addr, va);
        chk("wb_data", wr_data, vd);
      end
      if (got_done) m_fill = exp_fill;
      if (reached_wait) m_shared = acc_sh;
    end
  endtask

  initial begin
    int k;
    rst_n = 1'b0; PrRd = 1'b0; PrWr = 1'b0; Address = 32'd0;
    Current_MESI_state_proc = 2'b00; Victim_MESI_state = 2'b00;
    Victim_address = 32'd0; Victim_data = 32'd0; Bus_grant = 1'b0;
    Data_Bus_Com_in = 32'd0; Shared = 1'b0; Snoop_done = 1'b0; Mem_ready = 1'b0;
    m_fill = 32'd0; m_shared = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("idle_after_reset");

    // Read hit on E; then a write hit on M.
    run_txn(1'b1, 1'b0, 2'b10, 2'b11, 0, 0, 0, 0, 0, 32'h0000_2040, 32'h0, 32'h0, 32'h0, 0);
    run_txn(1'b0, 1'b1, 2'b11, 2'b11, 0, 0, 0, 0, 0, 32'h0000_2080, 32'h0, 32'h0, 32'h0, 0);
    // Read miss, clean victim, immediate grant and responses, Shared asserted.
    run_txn(1'b1, 1'b0, 2'b00, 2'b01, 0, 0, 0, 0, 1, 32'h0000_3000, 32'h0, 32'h0, 32'hDEAD_BEEF, 0);
    // Write miss with Modified victim writeback.
    run_txn(1'b0, 1'b1, 2'b00, 2'b11, 1, 2, 1, 2, 0, 32'h0000_4000, 32'h0000_1000, 32'h0000_0055, 32'h1234_5678, 0);
    // Upgrade from S: completes on Snoop_done alone, fill data untouched.
    run_txn(1'b0, 1'b1, 2'b01, 2'b00, 0, 0, 0, 50, 0, 32'h0000_5000, 32'h0, 32'h0, 32'hAAAA_AAAA, 0);
    // Shared read is a hit; both PrRd and PrWr on an I line is a write miss.
    run_txn(1'b1, 1'b0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 32'h0000_5100, 32'h0, 32'h0, 32'h0, 0);
    run_txn(1'b1, 1'b1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 32'h0000_5200, 32'h0, 32'h0, 32'h0BAD_F00D, 0);
    // Timeouts: grant never, writeback never acknowledged, snoop never done.
    run_txn(1'b1, 1'b0, 2'b00, 2'b00, 100, 0, 0, 0, 0, 32'h0000_6000, 32'h0, 32'h0, 32'h0, 0);
    run_txn(1'b0, 1'b1, 2'b00, 2'b11, 0, 100, 0, 0, 0, 32'h0000_6100, 32'h0000_0100, 32'h0000_0077, 32'h0, 0);
    run_txn(1'b1, 1'b0, 2'b00, 2'b00, 0, 0, 100, 0, 0, 32'h0000_6200, 32'h0, 32'h0, 32'h0, 0);
    // Long but in-budget grant delay.
    run_txn(1'b1, 1'b0, 2'b00, 2'b00, 13, 0, 0, 0, 0, 32'h0000_6300, 32'h0, 32'h0, 32'h0000_6363, 0);
    // Asynchronous reset in WAIT, then a normal miss.
    run_txn(1'b1, 1'b0, 2'b00, 2'b00, 0, 0, 3, 3, 0, 32'h0000_7000, 32'h0, 32'h0, 32'h7777_7777, 1);
    run_txn(1'b1, 1'b0, 2'b00, 2'b01, 0, 0, 0, 0, 1, 32'h0000_7100, 32'h0, 32'h0, 32'hCAFE_F00D, 0);

    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(1, 3);
      run_txn(k[0], k[1], 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              $urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 6),
              $urandom_range(0, 1), $urandom, $urandom, $urandom, $urandom, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_initiator.md
# bus_initiator

Per-cache bus-side transaction engine that turns a processor miss or write-upgrade into a MESI bus transaction on the shared snoop bus. It sits between one processor's cache block/MESI controller and the common Address_Com/Data_Bus_Com bus. It arbitrates for the bus, optionally writes back a Modified victim, issues BusRd, BusRdX or Invalidate, and collects Shared and fill data. It reports completion so the MESI controller can commit the new line state.

## Interface
- ADDRESSSIZE, 32, address and data width
- MESI_SIZE, 2, MESI state encoding width
- TIMEOUT, 15, maximum cycles spent waiting for a bus or memory response before aborting
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous and active-low
- PrRd, PrWr  input  1  processor request, level, held until Pr_done
- Address  input  ADDRESSSIZE  processor request address
- Current_MESI_state_proc  input  MESI_SIZE  state of the addressed line (INVALID = miss)
- Victim_MESI_state  input  MESI_SIZE  state of the LRU victim way
- Victim_address  input  ADDRESSSIZE  block address of the victim
- Victim_data  input  ADDRESSSIZE  victim data word
- Bus_req  output  1  request or hold the common bus
- Bus_grant  input  1  grant from the external arbiter
- BusRd, BusRdX, Invalidate, Mem_wr  output  1  bus command strobes
- Address_Com  output  ADDRESSSIZE  bus address, valid only during a command strobe; otherwise 0
- Data_Bus_Com_out  output  ADDRESSSIZE  writeback data, valid with Mem_wr
- Data_Bus_Com_in  input  ADDRESSSIZE  fill data from memory or a flushing peer
- Shared  input  1  wired-OR snoop response from other caches
- Snoop_done  input  1  all peers have finished snooping and any flush
- Mem_ready  input  1  memory has accepted the write or supplied the data
- Fill_data  output  ADDRESSSIZE  captured fill word
- Fill_shared  output  1  latched Shared seen during the transaction
- Pr_done  output  1  one-cycle completion pulse
- Bus_error  output  1  one-cycle timeout pulse

## Operation
- States: IDLE, ARB, WB, ISSUE, WAIT, DONE.
- IDLE accepts a request when PrRd or PrWr is high. If both are high, the request is a write. At acceptance the block latches the address, the command, the victim address and data, and the writeback flag.
- Command classification:
  - M or E (any request), or S with a read: hit. Go to DONE with no bus activity.
  - S with a write: Invalidate.
  - I with a read: BusRd.
  - I with a write: BusRdX.
  - The writeback flag is set when the command is BusRd or BusRdX and Victim_MESI_state is MODIFIED.
- ARB: Bus_req=1. When Bus_grant is sampled high, go to WB if the writeback flag is set, otherwise to ISSUE. Bus_req stays high from ARB until DONE.
- WB:
  - Drive Mem_wr with Address_Com=victim address and Data_Bus_Com_out=victim data.
  - Mem_wr is driven on the first WB cycle only; the block then holds in WB until Mem_ready.
  - On Mem_ready go to ISSUE.
- ISSUE: drive the command strobe for exactly one cycle with Address_Com=request address, then go to WAIT.
- WAIT:
  - Fill_shared accumulates as the OR of Shared over all WAIT cycles.
  - Completion condition: Snoop_done, and additionally Mem_ready for BusRd/BusRdX.
  - On that cycle capture Data_Bus_Com_in into Fill_data (BusRd/BusRdX only), then go to DONE.
- DONE: pulse Pr_done, drop Bus_req, return to IDLE. A new request may be accepted in the following cycle.
- Timeout:
  - A counter clears on every state entry and increments in ARB, WB and WAIT.
  - When it reaches TIMEOUT, pulse Bus_error, drop Bus_req and go to IDLE. Pr_done is not pulsed.
- Bus_grant high while Bus_req is low is ignored. Bus_grant dropping while the block holds the bus has no effect on an in-flight transaction.
- Inputs that change after acceptance are ignored until IDLE.

## Timing
- Reset: all outputs 0 and state IDLE. An asynchronous reset mid-transaction releases the bus and drops any strobe immediately.
- Hit latency: request in cycle 0, Pr_done in cycle 1.
- Miss without writeback, grant returned immediately, and Snoop_done with Mem_ready returned in the first WAIT cycle: ARB in cycle 1, ISSUE in cycle 2, WAIT in cycle 3, Pr_done in cycle 4.
- A writeback adds at least 1 cycle (WB) plus the wait for Mem_ready.
- Fill_data and Fill_shared are registered, hold until the next transaction's WAIT, and are valid when Pr_done is high.
- Strobes are registered and mutually exclusive: at most one command strobe is high per cycle.

## Structure
- Shared package holds:
  - MESI encodings: INVALID=00, SHARED=01, EXCLUSIVE=10, MODIFIED=11
  - state encodings
  - command encodings
  - ADDRESSSIZE and MESI_SIZE
- A single module. The timeout counter stays inline.

## Test plan
- Read hit: state=E, PrRd -> Pr_done at cycle 1, Bus_req never asserted.
- Read miss: state=I, victim=S, grant immediate, Shared=1 in WAIT, Snoop_done=Mem_ready=1, Data_Bus_Com_in=0xDEADBEEF -> one BusRd pulse with Address_Com=Address, Fill_data=0xDEADBEEF, Fill_shared=1, Pr_done at cycle 4.
- Write miss with writeback: state=I, victim=M at 0x1000 with data 0x55 -> Mem_wr with 0x1000/0x55, then BusRdX after Mem_ready, then Pr_done.
- Upgrade: state=S, PrWr, Snoop_done=1, Mem_ready=0 -> one Invalidate pulse, completes without Mem_ready, Fill_data unchanged.
- Timeout: Bus_grant held 0 -> Bus_error after 15 ARB cycles, Bus_req drops, no Pr_done.
- Reset mid-WAIT: rst_n low -> all outputs 0 immediately, and the next request is serviced normally.
